// File: rtl/cla_pipe_adder_if.sv
// Operand/result bundle for cla_pipe_adder; Ovf_out exists only with CLA_PIPE_OVF_EN.
// master drives operands and Out_ready, slave (the adder) drives In_ready and results.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             In_valid;
    logic             In_ready;
    logic [WIDTH-1:0] Sum_out;
    logic             Cout_out;
    logic             Out_valid;
    logic             Out_ready;
`ifdef CLA_PIPE_OVF_EN
    logic             Ovf_out;
`endif

    modport master (
        output A, B, Cin, Sub, In_valid, Out_ready,
        input  In_ready, Sum_out, Cout_out, Out_valid
`ifdef CLA_PIPE_OVF_EN
        , input Ovf_out
`endif
    );

    modport slave (
        input  A, B, Cin, Sub, In_valid, Out_ready,
        output In_ready, Sum_out, Cout_out, Out_valid
`ifdef CLA_PIPE_OVF_EN
        , output Ovf_out
`endif
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Two-stage carry-lookahead add/subtract (4-bit groups + group lookahead); Ovf_out with CLA_PIPE_OVF_EN.
// Latency: 2 edges from accept to Out_valid; one op per cycle while Out_ready=1.
// Backpressure: stage 1 holds one op behind a stalled output; In_ready drops once both are full.
module cla_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    cla_pipe_adder_if.slave   io
);
    localparam int NG = WIDTH / 4;

    // Sum-of-products carry into position n of a chain (lookahead form, no ripple).
    function automatic logic la_carry(input logic [15:0] g, input logic [15:0] p,
                                      input logic c0, input int n);
        logic c;
        logic t;
        t = c0;
        for (int m = 0; m < 16; m++) if (m < n) t = t & p[m];
        c = t;
        for (int j = 0; j < 16; j++) begin
            if (j < n) begin
                t = g[j];
                for (int m = 0; m < 16; m++) if (m > j && m < n) t = t & p[m];
                c = c | t;
            end
        end
        return c;
    endfunction

    // ---------------- stage 1: bit and group propagate/generate ----------------
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] bit_p;
    logic [WIDTH-1:0] bit_g;
    logic [NG-1:0]    grp_p;
    logic [NG-1:0]    grp_g;
    logic             cin_eff;

    assign b_eff   = io.Sub ? ~io.B : io.B;
    assign cin_eff = io.Sub | io.Cin;
    assign bit_p   = io.A ^ b_eff;
    assign bit_g   = io.A & b_eff;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        assign grp_p[k] = &bit_p[4*k +: 4];
        assign grp_g[k] = la_carry(16'(bit_g[4*k +: 4]), 16'(bit_p[4*k +: 4]), 1'b0, 4);
    end

    logic             s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0] s1_p_q,   s1_p_d;
    logic [WIDTH-1:0] s1_g_q,   s1_g_d;
    logic [NG-1:0]    s1_gp_q,  s1_gp_d;
    logic [NG-1:0]    s1_gg_q,  s1_gg_d;
    logic             s1_cin_q, s1_cin_d;

    // ---------------- stage 2: group carries, bit carries, sum ----------------
    logic [NG:0]      grp_c;
    logic [WIDTH:0]   bit_c;
    logic [WIDTH-1:0] add_sum;

    for (genvar k = 0; k <= NG; k++) begin : g_gc
        assign grp_c[k] = la_carry(16'(s1_gg_q), 16'(s1_gp_q), s1_cin_q, k);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bc
        assign bit_c[i] = la_carry(16'(s1_g_q[4*(i/4) +: 4]), 16'(s1_p_q[4*(i/4) +: 4]),
                                   grp_c[i/4], i % 4);
    end
    assign bit_c[WIDTH] = grp_c[NG];
    assign add_sum      = s1_p_q ^ bit_c[WIDTH-1:0];

    logic             out_vld_q,  out_vld_d;
    logic [WIDTH-1:0] sum_q,      sum_d;
    logic             cout_q,     cout_d;
`ifdef CLA_PIPE_OVF_EN
    logic             ovf_q,      ovf_d;
`endif

    // ---------------- handshake ----------------
    logic accept;
    logic drain;
    logic out_load;

    assign drain       = out_vld_q & io.Out_ready;
    assign out_load    = s1_vld_q & (~out_vld_q | io.Out_ready);
    // Reset forces In_ready high, but accept is gated so reset edges take nothing in.
    assign io.In_ready = Reset | ~s1_vld_q | ~out_vld_q | io.Out_ready;
    assign accept      = io.In_valid & io.In_ready & ~Reset;

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_p_d   = s1_p_q;
        s1_g_d   = s1_g_q;
        s1_gp_d  = s1_gp_q;
        s1_gg_d  = s1_gg_q;
        s1_cin_d = s1_cin_q;
        if (accept) begin
            s1_vld_d = 1'b1;
            s1_p_d   = bit_p;
            s1_g_d   = bit_g;
            s1_gp_d  = grp_p;
            s1_gg_d  = grp_g;
            s1_cin_d = cin_eff;
        end else if (out_load) begin
            s1_vld_d = 1'b0;
        end
    end

    always_comb begin
        out_vld_d = out_vld_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
`ifdef CLA_PIPE_OVF_EN
        ovf_d     = ovf_q;
`endif
        if (out_load) begin
            out_vld_d = 1'b1;
            sum_d     = add_sum;
            cout_d    = bit_c[WIDTH];
`ifdef CLA_PIPE_OVF_EN
            ovf_d     = bit_c[WIDTH-1] ^ bit_c[WIDTH];
`endif
        end else if (drain) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
`ifdef CLA_PIPE_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            s1_vld_q  <= s1_vld_d;
            out_vld_q <= out_vld_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
`ifdef CLA_PIPE_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    // Payload registers are qualified by s1_vld_q and need no reset.
    always_ff @(posedge Clk) begin
        s1_p_q   <= s1_p_d;
        s1_g_q   <= s1_g_d;
        s1_gp_q  <= s1_gp_d;
        s1_gg_q  <= s1_gg_d;
        s1_cin_q <= s1_cin_d;
    end

    assign io.Sum_out   = sum_q;
    assign io.Cout_out  = cout_q;
    assign io.Out_valid = out_vld_q;
`ifdef CLA_PIPE_OVF_EN
    assign io.Ovf_out   = ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder at WIDTH=16: directed vectors, backpressure, reset, random stream.
module tb_cla_pipe_adder;
    localparam int W = 16;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    cla_pipe_adder_if #(.WIDTH(W)) bus ();

    cla_pipe_adder #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .io    (bus)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp;
    int   errors = 0;
    int   checks = 0;
    int   n_out  = 0;
    logic acc;
    logic rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [W-1:0] be;
        logic [W:0]   r;
        be     = sub ? ~b : b;
        r      = {1'b0, a} + {1'b0, be} + (W+1)'(sub ? 1'b1 : cin);
        e.sum  = r[W-1:0];
        e.cout = r[W];
        e.ovf  = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o;
        return e;
    endfunction

    task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input exp_t e);
        bus.A = a; bus.B = b; bus.Cin = cin; bus.Sub = sub;
        bus.In_valid = 1'b1;
        cur_exp = e;
    endtask

    // Called at negedge+1; samples the handshake at negedge+2, returns at next negedge+1.
    task automatic tick(output logic accepted, output logic ready_seen);
        #1;
        ready_seen = bus.In_ready;
        accepted   = bus.In_valid && bus.In_ready && !Reset;
        if (accepted) exp_q.push_back(cur_exp);
        @(negedge Clk);
        #1;
        if (Reset) exp_q.delete();
    endtask

    // Monitor: a result transfers on the coming edge when Out_valid && Out_ready.
    always @(negedge Clk) begin
        exp_t e;
        #3;
        if (!Reset && bus.Out_valid && bus.Out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got sum 0x%0h cout %0d, expected no result",
                         bus.Sum_out, bus.Cout_out);
            end else begin
                e = exp_q.pop_front();
                chk("result_sum", bus.Sum_out, e.sum);
                chk("result_cout", bus.Cout_out, e.cout);
`ifdef CLA_PIPE_OVF_EN
                chk("result_ovf", bus.Ovf_out, e.ovf);
`endif
                n_out++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted_ops;
        int cyc;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;
        logic rs;

        Reset = 1'b1;
        bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.Sub = 1'b0;
        bus.In_valid = 1'b0;
        bus.Out_ready = 1'b1;
        cur_exp = mk('0, 1'b0, 1'b0);
        @(negedge Clk);
        #1;

        // Reset state
        tick(acc, rdy);
        chk("reset_in_ready", rdy, 1);
        tick(acc, rdy);
        Reset = 1'b0;
        chk("reset_out_valid", bus.Out_valid, 0);
        chk("reset_sum", bus.Sum_out, 0);
        chk("reset_cout", bus.Cout_out, 0);

        // Basic add with latency and single-cycle valid
        offer(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        tick(acc, rdy);
        chk("add_accept", acc, 1);
        bus.In_valid = 1'b0;
        chk("latency_stage1_only", bus.Out_valid, 0);
        tick(acc, rdy);
        chk("latency_out_valid", bus.Out_valid, 1);
        chk("add_sum_direct", bus.Sum_out, 16'h0000);
        tick(acc, rdy);
        chk("valid_one_cycle", bus.Out_valid, 0);

        // Subtract, back to back; Cin ignored in subtract mode
        offer(16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
        tick(acc, rdy);
        chk("sub1_accept", acc, 1);
        offer(16'h0007, 16'h0005, 1'b0, 1'b1, mk(16'h0002, 1'b1, 1'b0));
        tick(acc, rdy);
        chk("sub2_accept", acc, 1);
        bus.In_valid = 1'b0;
        repeat (3) tick(acc, rdy);

        // Signed overflow cases (sum/cout always checked, ovf when present)
        offer(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
        tick(acc, rdy);
        offer(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
        tick(acc, rdy);
        bus.In_valid = 1'b0;
        repeat (3) tick(acc, rdy);

        // Backpressure
        bus.Out_ready = 1'b0;
        offer(16'h0001, 16'h0001, 1'b0, 1'b0, mk(16'h0002, 1'b0, 1'b0));
        tick(acc, rdy);
        chk("bp_accept1", acc, 1);
        offer(16'h0002, 16'h0002, 1'b0, 1'b0, mk(16'h0004, 1'b0, 1'b0));
        tick(acc, rdy);
        chk("bp_accept2", acc, 1);
        offer(16'h0003, 16'h0003, 1'b0, 1'b0, mk(16'h0006, 1'b0, 1'b0));
        tick(acc, rdy);
        chk("bp_in_ready_low", rdy, 0);
        tick(acc, rdy);
        chk("bp_still_low", rdy, 0);
        chk("bp_hold_valid", bus.Out_valid, 1);
        chk("bp_hold_sum", bus.Sum_out, 16'h0002);
        bus.Out_ready = 1'b1;
        tick(acc, rdy);
        chk("bp_drain_accept", acc, 1);
        bus.In_valid = 1'b0;
        repeat (4) tick(acc, rdy);

        // Reset mid-flight: accepted op must never appear
        offer(16'h1234, 16'h1111, 1'b0, 1'b0, mk(16'h2345, 1'b0, 1'b0));
        tick(acc, rdy);
        chk("flight_accept", acc, 1);
        bus.In_valid = 1'b0;
        Reset = 1'b1;
        tick(acc, rdy);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(acc, rdy);
            chk("flight_out_valid_low", bus.Out_valid, 0);
        end

        // Reset with a stalled full pipeline and In_valid held high
        bus.Out_ready = 1'b0;
        offer(16'h0010, 16'h0020, 1'b0, 1'b0, mk(16'h0030, 1'b0, 1'b0));
        tick(acc, rdy);
        offer(16'h0040, 16'h0050, 1'b0, 1'b0, mk(16'h0090, 1'b0, 1'b0));
        tick(acc, rdy);
        offer(16'h0100, 16'h0200, 1'b0, 1'b0, mk(16'h0300, 1'b0, 1'b0));
        Reset = 1'b1;
        tick(acc, rdy);
        chk("stall_reset_in_ready", rdy, 1);
        Reset = 1'b0;
        bus.In_valid = 1'b0;
        bus.Out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(acc, rdy);
            chk("stall_reset_out_valid_low", bus.Out_valid, 0);
        end

        // Random streaming with random valid/ready
        accepted_ops = 0;
        cyc = 0;
        while (accepted_ops < 1000 && cyc < 20000) begin
            if (!bus.In_valid && $urandom_range(0, 3) != 0) begin
                ra = W'($urandom);
                rb = W'($urandom);
                rc = 1'($urandom_range(0, 1));
                rs = 1'($urandom_range(0, 1));
                offer(ra, rb, rc, rs, model(ra, rb, rc, rs));
            end
            bus.Out_ready = ($urandom_range(0, 3) != 0);
            tick(acc, rdy);
            if (acc) begin
                accepted_ops++;
                bus.In_valid = 1'b0;
            end
            cyc++;
        end
        chk("random_all_accepted", accepted_ops, 1000);
        bus.In_valid = 1'b0;
        bus.Out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            tick(acc, rdy);
            cyc++;
        end
        chk("random_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
